// File: rtl/fround_lanes.sv
// fround_lanes: multi-lane requantizer from wide signed accumulator words to
// narrow signed output words. Each beat carries its own fraction shift and
// rounding mode. Per-lane clamp/overflow/underflow flags are produced, and a
// counter tracks delivered beats that clamped in any lane.
// Stage p1 holds the rounded value at INWIDTH+1 bits. Stage p2 holds the
// clamped result and flags, and drives the outputs. Both stages advance
// together whenever the output register is empty or being drained.
module fround_lanes #(
    parameter int LANES    = 4,
    parameter int INWIDTH  = 33,
    parameter int OUTWIDTH = 16,
    parameter int SHIFT_W  = 5,
    parameter int CNT_W    = 16
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [LANES*INWIDTH-1:0]     DIN,
    input  logic [SHIFT_W-1:0]           SHIFT,
    input  logic [1:0]                   MODE,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [LANES*OUTWIDTH-1:0]    DOUT,
    output logic [LANES-1:0]             SATUR,
    output logic [LANES-1:0]             OVFL,
    output logic [LANES-1:0]             UDFL,
    output logic [CNT_W-1:0]             SAT_CNT,
    input  logic                         CNT_CLR
);

    // One guard bit above the input width so a rounding carry cannot wrap.
    localparam int YW = INWIDTH + 1;
    localparam logic signed [YW-1:0] MAX_Y =
        $signed({{(YW-OUTWIDTH+1){1'b0}}, {(OUTWIDTH-1){1'b1}}});
    localparam logic signed [YW-1:0] MIN_Y =
        $signed({{(YW-OUTWIDTH+1){1'b1}}, {(OUTWIDTH-1){1'b0}}});
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Drops s fraction bits from x using the selected rounding mode.
    // The remainder is the low s bits of x. The half point is the top bit of the
    // low-bit mask, so it is zero when s is zero.
    function automatic logic signed [YW-1:0] round_lane(
        input logic signed [INWIDTH-1:0] x,
        input logic [SHIFT_W-1:0]        s,
        input logic [1:0]                mode
    );
        logic signed [YW-1:0] xe;
        logic signed [YW-1:0] q;
        logic [INWIDTH-1:0]   mask;
        logic [INWIDTH-1:0]   rem;
        logic [INWIDTH-1:0]   half;
        logic                 inc;
        xe   = $signed({x[INWIDTH-1], x});
        q    = xe >>> s;
        mask = (INWIDTH'(1) << s) - INWIDTH'(1);
        rem  = $unsigned(x) & mask;
        half = mask ^ (mask >> 1);
        case (mode)
            2'b00:   inc = 1'b0;
            2'b10:   inc = (s != '0) && ((rem > half) || ((rem == half) && q[0]));
            default: inc = (s != '0) && (rem >= half);
        endcase
        return q + $signed({{(YW-1){1'b0}}, inc});
    endfunction

    // Clamps a rounded value to the output range: {ovfl, satur, dout}.
    function automatic logic [OUTWIDTH+1:0] sat_lane(input logic signed [YW-1:0] y);
        if (y > MAX_Y)
            return {1'b1, 1'b1, MAX_Y[OUTWIDTH-1:0]};
        else if (y < MIN_Y)
            return {1'b0, 1'b1, MIN_Y[OUTWIDTH-1:0]};
        return {2'b00, y[OUTWIDTH-1:0]};
    endfunction

    logic                    w_adv;
    logic signed [YW-1:0]    w_y [LANES];
    logic [LANES-1:0]        w_nz;
    logic [OUTWIDTH+1:0]     w_sat [LANES];
    logic [LANES*OUTWIDTH-1:0] w_dout;
    logic [LANES-1:0]        w_satur;
    logic [LANES-1:0]        w_ovfl;
    logic [LANES-1:0]        w_udfl;

    logic                    r_vld_p1;
    logic signed [YW-1:0]    r_y_p1 [LANES];
    logic [LANES-1:0]        r_nz_p1;

    logic                    r_vld_p2;
    logic [LANES*OUTWIDTH-1:0] r_dout_p2;
    logic [LANES-1:0]        r_satur_p2;
    logic [LANES-1:0]        r_ovfl_p2;
    logic [LANES-1:0]        r_udfl_p2;
    logic [CNT_W-1:0]        r_cnt;

    assign w_adv    = !r_vld_p2 || OUT_READY;
    assign IN_READY = w_adv;

    // ---- stage p0 -> p1: round every lane of the incoming beat ----
    always_comb begin
        w_nz = '0;
        for (int i = 0; i < LANES; i++) begin
            w_y[i]  = round_lane($signed(DIN[i*INWIDTH +: INWIDTH]), SHIFT, MODE);
            w_nz[i] = |DIN[i*INWIDTH +: INWIDTH];
        end
    end

    // Stage p1 valid: a bubble is loaded when no beat is offered.
    always_ff @(posedge CLK) begin
        if (!RESET_N)
            r_vld_p1 <= 1'b0;
        else if (w_adv)
            r_vld_p1 <= IN_VALID;
    end

    // Stage p1 data: only meaningful while r_vld_p1 is set.
    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_y_p1  <= w_y;
            r_nz_p1 <= w_nz;
        end
    end

    // ---- stage p1 -> p2: clamp to the output range and derive flags ----
    always_comb begin
        w_dout  = '0;
        w_satur = '0;
        w_ovfl  = '0;
        w_udfl  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sat[i] = sat_lane(r_y_p1[i]);
            w_dout[i*OUTWIDTH +: OUTWIDTH] = w_sat[i][OUTWIDTH-1:0];
            w_satur[i] = w_sat[i][OUTWIDTH];
            w_ovfl[i]  = w_sat[i][OUTWIDTH+1];
            w_udfl[i]  = r_nz_p1[i] && (r_y_p1[i] == '0);
        end
    end

    // Stage p2 output register; cleared on reset so outputs read zero.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_vld_p2   <= 1'b0;
            r_dout_p2  <= '0;
            r_satur_p2 <= '0;
            r_ovfl_p2  <= '0;
            r_udfl_p2  <= '0;
        end else if (w_adv) begin
            r_vld_p2   <= r_vld_p1;
            r_dout_p2  <= w_dout;
            r_satur_p2 <= w_satur;
            r_ovfl_p2  <= w_ovfl;
            r_udfl_p2  <= w_udfl;
        end
    end

    // Saturation event counter: one count per delivered clamping beat, sticky at max.
    always_ff @(posedge CLK) begin
        if (!RESET_N || CNT_CLR)
            r_cnt <= '0;
        else if (r_vld_p2 && OUT_READY && (|r_satur_p2) && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign OUT_VALID = r_vld_p2;
    assign DOUT      = r_dout_p2;
    assign SATUR     = r_satur_p2;
    assign OVFL      = r_ovfl_p2;
    assign UDFL      = r_udfl_p2;
    assign SAT_CNT   = r_cnt;

endmodule
